// File: rtl/vend_act_pkg.sv
// Shared definitions for the vending actuator: FSM state encodings and
// default timing/queue parameters.
package vend_act_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_MOTOR     = 3'd1,
    ST_WAIT_DROP = 3'd2,
    ST_SOL       = 3'd3,
    ST_WAIT_COIN = 3'd4,
    ST_FAULT     = 3'd5
  } state_t;

  localparam int unsigned MOTOR_CYCLES_DEF = 8;
  localparam int unsigned SOL_CYCLES_DEF   = 4;
  localparam int unsigned TIMEOUT_DEF      = 32;
  localparam int unsigned PEND_W_DEF       = 3;

  function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/sat_updown_cnt.sv
// Saturating up/down request counter with a sticky overflow flag that is set
// when an increment is lost at the top of the range.
module sat_updown_cnt #(
  parameter int unsigned W = 3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc_i,
  input  logic         dec_i,
  output logic [W-1:0] cnt_o,
  output logic         ovf_o
);

  localparam logic [W-1:0] CNT_MAX = '1;

  logic [W-1:0] cnt_q, cnt_d;
  logic         ovf_q, ovf_d;

  always_comb begin
    cnt_d = cnt_q;
    ovf_d = ovf_q;
    if (inc_i && !dec_i) begin
      if (cnt_q == CNT_MAX) ovf_d = 1'b1;
      else                  cnt_d = cnt_q + 1'b1;
    end else if (dec_i && !inc_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      ovf_q <= ovf_d;
    end
  end

  assign cnt_o = cnt_q;
  assign ovf_o = ovf_q;

endmodule

// File: rtl/vend_actuator.sv
// Drives the product motor and change solenoid from queued x/y requests,
// waits for the matching sensor and latches a fault on sensor timeout.
module vend_actuator
  import vend_act_pkg::*;
#(
  parameter int unsigned MOTOR_CYCLES = MOTOR_CYCLES_DEF,
  parameter int unsigned SOL_CYCLES   = SOL_CYCLES_DEF,
  parameter int unsigned TIMEOUT      = TIMEOUT_DEF,
  parameter int unsigned PEND_W       = PEND_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              x,
  input  logic              y,
  input  logic              drop_sns,
  input  logic              coin_sns,
  input  logic              clr_fault,
  output logic              motor,
  output logic              sol,
  output logic              busy,
  output logic              fault,
  output logic              ovf,
  output logic              vend_done,
  output logic              coin_done,
  output logic [PEND_W-1:0] prod_pend,
  output logic [PEND_W-1:0] coin_pend
);

  localparam int unsigned TMR_MAX = max3(MOTOR_CYCLES, SOL_CYCLES, TIMEOUT);
  localparam int unsigned TMR_W   = $clog2(TMR_MAX + 1);
  localparam logic [TMR_W-1:0] MOTOR_LAST = TMR_W'(MOTOR_CYCLES - 1);
  localparam logic [TMR_W-1:0] SOL_LAST   = TMR_W'(SOL_CYCLES - 1);
  localparam logic [TMR_W-1:0] WAIT_LAST  = TMR_W'(TIMEOUT - 1);

  state_t             state_q, state_d;
  logic [TMR_W-1:0]   tmr_q, tmr_d;
  logic [PEND_W-1:0]  prod_cnt, coin_cnt;
  logic               prod_ovf, coin_ovf;
  logic               prod_start, coin_start;

  logic motor_q, motor_d, sol_q, sol_d, busy_q, busy_d, fault_q, fault_d;
  logic vend_done_q, vend_done_d, coin_done_q, coin_done_d;

  // Product jobs take priority; a coin job starts only with no product queued.
  assign prod_start = (state_q == ST_IDLE) && (prod_cnt != '0);
  assign coin_start = (state_q == ST_IDLE) && (prod_cnt == '0) && (coin_cnt != '0);

  sat_updown_cnt #(.W(PEND_W)) u_prod_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc_i (x),
    .dec_i (prod_start),
    .cnt_o (prod_cnt),
    .ovf_o (prod_ovf)
  );

  sat_updown_cnt #(.W(PEND_W)) u_coin_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc_i (y),
    .dec_i (coin_start),
    .cnt_o (coin_cnt),
    .ovf_o (coin_ovf)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      tmr_q   <= '0;
    end else begin
      state_q <= state_d;
      tmr_q   <= tmr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (prod_start)      state_d = ST_MOTOR;
        else if (coin_start) state_d = ST_SOL;
      end
      ST_MOTOR:     if (tmr_q == MOTOR_LAST) state_d = ST_WAIT_DROP;
      ST_WAIT_DROP: begin
        if (drop_sns)                state_d = ST_IDLE;
        else if (tmr_q == WAIT_LAST) state_d = ST_FAULT;
      end
      ST_SOL:       if (tmr_q == SOL_LAST) state_d = ST_WAIT_COIN;
      ST_WAIT_COIN: begin
        if (coin_sns)                state_d = ST_IDLE;
        else if (tmr_q == WAIT_LAST) state_d = ST_FAULT;
      end
      ST_FAULT:     if (clr_fault) state_d = ST_IDLE;
      default:      state_d = ST_IDLE;
    endcase
    // Phase timer restarts on every transition and rests at zero when idle/faulted.
    if ((state_d != state_q) || (state_q == ST_IDLE) || (state_q == ST_FAULT))
      tmr_d = '0;
    else
      tmr_d = tmr_q + 1'b1;
  end

  always_comb begin
    motor_d     = (state_d == ST_MOTOR);
    sol_d       = (state_d == ST_SOL);
    busy_d      = (state_d != ST_IDLE);
    fault_d     = (state_d == ST_FAULT);
    vend_done_d = (state_q == ST_WAIT_DROP) && drop_sns;
    coin_done_d = (state_q == ST_WAIT_COIN) && coin_sns;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      motor_q     <= 1'b0;
      sol_q       <= 1'b0;
      busy_q      <= 1'b0;
      fault_q     <= 1'b0;
      vend_done_q <= 1'b0;
      coin_done_q <= 1'b0;
    end else begin
      motor_q     <= motor_d;
      sol_q       <= sol_d;
      busy_q      <= busy_d;
      fault_q     <= fault_d;
      vend_done_q <= vend_done_d;
      coin_done_q <= coin_done_d;
    end
  end

  assign motor     = motor_q;
  assign sol       = sol_q;
  assign busy      = busy_q;
  assign fault     = fault_q;
  assign vend_done = vend_done_q;
  assign coin_done = coin_done_q;
  assign ovf       = prod_ovf | coin_ovf;
  assign prod_pend = prod_cnt;
  assign coin_pend = coin_cnt;

endmodule
